// File: rtl/bnn_dot_engine.sv
// Streaming XNOR-popcount dot-product engine for packed +/-1 operands.
// Accumulates ms word pairs per operation and returns the signed dot product or a threshold bit.
module bnn_dot_engine #(
  parameter int XLEN   = 32,
  parameter int MAX_MS = 16,
  parameter int ACC_W  = $clog2(MAX_MS*XLEN+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_ms_we,
  input  logic            cfg_at_we,
  input  logic [XLEN-1:0] cfg_data,
  output logic            cfg_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_thresh,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  // state | meaning
  // IDLE  | waiting for the first beat; config writes honoured
  // ACCUM | accumulating beats until cnt reaches the latched ms
  // DONE  | result held on out_result until out_ready
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int CNT_W = $clog2(MAX_MS+1);
  localparam int CMP_W = (XLEN > ACC_W+2) ? XLEN : ACC_W+2;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  ms_q, ms_d, op_ms_q, op_ms_d, cnt_q, cnt_d;
  logic [XLEN-1:0]   thr_q, thr_d, op_thr_q, op_thr_d, res_q, res_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              mode_q, mode_d, cfg_err_q, cfg_err_d;

  logic [XLEN-1:0]       xn, thr_use, dot_x, result_val;
  logic [ACC_W-1:0]      pc, acc_fin, ms_x;
  logic [CNT_W-1:0]      ms_use, cnt_inc;
  logic                  beat, mode_use;
  logic signed [ACC_W+1:0] dot_w;
  logic signed [CMP_W-1:0] dot_c, thr_c;

  always_comb begin
    state_d   = state_q;
    ms_d      = ms_q;
    thr_d     = thr_q;
    op_ms_d   = op_ms_q;
    op_thr_d  = op_thr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    res_d     = res_q;
    cfg_err_d = 1'b0;

    xn = ~(in_a ^ in_b);
    pc = '0;
    for (int i = 0; i < XLEN; i++) pc = pc + ACC_W'(xn[i]);

    beat    = in_valid && (state_q != DONE);
    cnt_inc = cnt_q + CNT_W'(1);

    // A first beat in IDLE must see the pre-write ms/thr, so use the live regs there
    ms_use   = (state_q == IDLE) ? ms_q : op_ms_q;
    thr_use  = (state_q == IDLE) ? thr_q : op_thr_q;
    mode_use = (state_q == IDLE) ? in_thresh : mode_q;
    acc_fin  = (state_q == IDLE) ? pc : acc_q + pc;

    ms_x  = ACC_W'(ms_use) << $clog2(XLEN);
    dot_w = $signed({1'b0, acc_fin, 1'b0}) - $signed({2'b00, ms_x});
    dot_x = XLEN'(dot_w);
    dot_c = CMP_W'(dot_w);
    thr_c = CMP_W'($signed(thr_use));
    result_val = mode_use ? {{(XLEN-1){1'b0}}, (dot_c >= thr_c)} : dot_x;

    if (state_q == IDLE) begin
      if (cfg_ms_we) begin
        if (cfg_data == '0)                ms_d = CNT_W'(1);
        else if (cfg_data > XLEN'(MAX_MS)) ms_d = CNT_W'(MAX_MS);
        else                               ms_d = CNT_W'(cfg_data);
      end
      if (cfg_at_we) thr_d = cfg_data;
    end else begin
      cfg_err_d = cfg_ms_we || cfg_at_we;
    end

    case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d    = pc;
          cnt_d    = CNT_W'(1);
          mode_d   = in_thresh;
          op_ms_d  = ms_q;
          op_thr_d = thr_q;
          if (ms_q == CNT_W'(1)) begin
            state_d = DONE;
            res_d   = result_val;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = acc_fin;
          cnt_d = cnt_inc;
          if (cnt_inc == op_ms_q) begin
            state_d = DONE;
            res_d   = result_val;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ms_q      <= CNT_W'(1);
      thr_q     <= '0;
      op_ms_q   <= CNT_W'(1);
      op_thr_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      res_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      thr_q     <= thr_d;
      op_ms_q   <= op_ms_d;
      op_thr_q  <= op_thr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      res_q     <= res_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign in_ready   = (state_q != DONE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = res_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_bnn_dot_engine.sv
// Scoreboard bench for bnn_dot_engine: expected results are queued as operations are driven
// and compared when the engine hands a result over.
module tb_bnn_dot_engine;

  logic        clk, reset;
  logic        cfg_ms_we, cfg_at_we, cfg_err;
  logic [31:0] cfg_data;
  logic        in_valid, in_ready, in_thresh;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, busy;
  logic [31:0] out_result;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] sb[$];
  logic [31:0] wa[16];
  logic [31:0] wb[16];
  int          ms_m = 1;
  int          thr_m = 0;
  logic [31:0] exp_last;

  bnn_dot_engine dut (
    .clk(clk), .reset(reset),
    .cfg_ms_we(cfg_ms_we), .cfg_at_we(cfg_at_we), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_thresh(in_thresh),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [31:0] w);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(w[i]);
    return c;
  endfunction

  function automatic logic [31:0] model(input int n, input logic th);
    int acc = 0;
    int dot;
    for (int k = 0; k < n; k++) acc += popc(~(wa[k] ^ wb[k]));
    dot = 2 * acc - ms_m * 32;
    if (th) return (dot >= thr_m) ? 32'd1 : 32'd0;
    return 32'(dot);
  endfunction

  // Results are compared as they are handed over (sampled half a cycle before the accepting edge).
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_result", out_result, 32'hDEAD_BEEF);
      else chk("result", out_result, sb.pop_front());
    end
  end

  // All drivers below start at posedge+1 and return at posedge+1.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic th);
    int t = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_thresh = th;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (t >= 100) chk("beat_timeout", 32'd1, 32'd0);
    tick();
    in_valid = 1'b0; in_thresh = 1'b0;
  endtask

  task automatic cfg_write(input logic ms_we, input logic at_we, input logic [31:0] data);
    cfg_ms_we = ms_we; cfg_at_we = at_we; cfg_data = data;
    tick();
    cfg_ms_we = 1'b0; cfg_at_we = 1'b0;
    if (ms_we) ms_m = (data == 0) ? 1 : (data > 16) ? 16 : int'(data);
    if (at_we) thr_m = $signed(data);
  endtask

  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++) begin
      wa[k] = $urandom; wb[k] = $urandom;
    end
  endtask

  // in_thresh is inverted on later beats: only the first beat may set the mode.
  task automatic run_op(input int n, input logic th, input int gap_after);
    exp_last = model(n, th);
    sb.push_back(exp_last);
    for (int k = 0; k < n; k++) begin
      send_beat(wa[k], wb[k], (k == 0) ? th : ~th);
      if (k == gap_after) tick();
    end
    @(negedge clk);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_ms_we = 0; cfg_at_we = 0; cfg_data = 0;
    in_valid = 0; in_a = 0; in_b = 0; in_thresh = 0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    tick();

    wa[0] = 32'hFFFF_0000; wb[0] = 32'hFFFF_0000;
    run_op(1, 1'b0, -1);
    chk("single_pos", exp_last, 32'd32);
    wa[0] = 32'h0; wb[0] = 32'hFFFF_FFFF;
    run_op(1, 1'b0, -1);
    chk("single_neg", exp_last, 32'hFFFF_FFE0);

    cfg_write(1, 0, 32'd4);
    cfg_write(0, 1, 32'd10);
    wa[0] = 32'h0;         wb[0] = 32'h0;
    wa[1] = 32'hFFFF_FFFF; wb[1] = 32'hFFFF_FFFF;
    wa[2] = 32'h0;         wb[2] = 32'h0000_FFFF;
    wa[3] = 32'h0;         wb[3] = 32'hFFFF_FFFF;
    run_op(4, 1'b1, 1);
    chk("thr10_model", exp_last, 32'd1);
    cfg_write(0, 1, 32'd33);
    run_op(4, 1'b1, 0);
    chk("thr33_model", exp_last, 32'd0);
    run_op(4, 1'b0, 2);

    // Backpressure: result must hold and no beat may be taken while DONE.
    out_ready = 1'b0;
    fill_rand(4);
    run_op(4, 1'b0, -1);
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_result", out_result, exp_last);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    cfg_write(1, 0, 32'd0);
    fill_rand(1);
    run_op(1, 1'b0, -1);
    cfg_write(1, 0, 32'd20);
    fill_rand(16);
    run_op(16, 1'b0, -1);

    // Write during ACCUM is dropped and flagged once.
    cfg_write(1, 0, 32'd4);
    fill_rand(4);
    exp_last = model(4, 1'b0);
    sb.push_back(exp_last);
    send_beat(wa[0], wb[0], 1'b0);
    send_beat(wa[1], wb[1], 1'b0);
    cfg_ms_we = 1'b1; cfg_data = 32'd2;
    @(negedge clk);
    chk("drop_err_early", {31'd0, cfg_err}, 32'd0);
    tick();
    cfg_ms_we = 1'b0;
    @(negedge clk);
    chk("drop_err_pulse", {31'd0, cfg_err}, 32'd1);
    chk("drop_busy", {31'd0, busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("drop_err_clear", {31'd0, cfg_err}, 32'd0);
    tick();
    send_beat(wa[2], wb[2], 1'b0);
    send_beat(wa[3], wb[3], 1'b0);
    @(negedge clk);
    chk("drop_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    fill_rand(4);
    run_op(4, 1'b0, -1);

    // Reset mid-operation: ms and thr return to 1 and 0.
    cfg_write(0, 1, 32'd100);
    fill_rand(2);
    send_beat(wa[0], wb[0], 1'b0);
    send_beat(wa[1], wb[1], 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ms_m = 1; thr_m = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wa[0] = 32'h0; wb[0] = 32'h0;
    run_op(1, 1'b1, -1);
    chk("mid_rst_thr_model", exp_last, 32'd1);

    cfg_write(1, 0, 32'd2);
    cfg_write(0, 1, 32'hFFFF_FFC0);
    wa[0] = 32'h0; wb[0] = 32'hFFFF_FFFF;
    wa[1] = 32'h0; wb[1] = 32'hFFFF_FFFF;
    run_op(2, 1'b1, -1);
    chk("neg_thr_model", exp_last, 32'd1);
    run_op(2, 1'b0, -1);
    chk("neg_raw_model", exp_last, 32'hFFFF_FFC0);

    // Both enables together write ms and thr from the same data.
    cfg_write(1, 1, 32'd3);
    fill_rand(3);
    run_op(3, 1'b1, -1);
    run_op(3, 1'b0, 0);

    // Beat and config write in the same IDLE cycle: the beat uses the old ms/thr.
    fill_rand(3);
    exp_last = model(3, 1'b1);
    sb.push_back(exp_last);
    cfg_ms_we = 1'b1; cfg_at_we = 1'b1; cfg_data = 32'd1;
    send_beat(wa[0], wb[0], 1'b1);
    cfg_ms_we = 1'b0; cfg_at_we = 1'b0;
    send_beat(wa[1], wb[1], 1'b0);
    send_beat(wa[2], wb[2], 1'b0);
    @(negedge clk);
    chk("same_cycle_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    ms_m = 1; thr_m = 1;
    fill_rand(1);
    run_op(1, 1'b1, -1);

    for (int t = 0; t < 50 && sb.size() != 0; t++) tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
